// File: rtl/booth_pkg.sv
// Shared types and constants for the booth multiplier arbiter slice.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_MUL_LAT = 9;

   // Bits needed to index n items; never less than one so a vector is always legal.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping at N_REQ. Produces a one-hot grant and its encoded index.
module rr_arbiter
   import booth_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  pointer,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   logic [ID_W-1:0] idx;

   // Walk the requesters starting at the pointer and keep the first hit.
   always_comb begin
      grant = '0;
      id    = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(pointer) + k) % N_REQ);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            id         = idx;
         end
      end
   end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one signed Booth multiplier among N_REQ requesters. One operand
// pair is accepted at a time, the multiplier is restarted with the operands
// held, and after MUL_LAT cycles the product is returned tagged with the id.
module booth_mul_arbiter
   import booth_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int WIDTH   = DEF_WIDTH,
   parameter  int MUL_LAT = DEF_MUL_LAT,
   localparam int ID_W    = clog2(N_REQ),
   localparam int CNT_W   = clog2(MUL_LAT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]     rsp_product,
   output logic                   mul_rst,
   output logic [WIDTH-1:0]       mul_a,
   output logic [WIDTH-1:0]       mul_b,
   input  logic [2*WIDTH-1:0]     mul_product,
   output logic                   busy
);

   state_t             state;
   logic [ID_W-1:0]    ptr;
   logic [CNT_W-1:0]   cnt;
   logic [ID_W-1:0]    lat_id;
   logic               mul_rst_q;

   logic [N_REQ-1:0]   grant;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic [ID_W-1:0]    next_ptr;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req     (req_valid),
      .pointer (ptr),
      .grant   (grant),
      .id      (gnt_id),
      .any     (gnt_any)
   );

   // The pointer moves just past whoever wins so that requester goes last next round.
   assign next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

   // Grants are only offered while idle and out of reset.
   assign req_ready = (rst && (state == IDLE)) ? grant : '0;

   // The multiplier is held in restart for the whole of our own reset as well.
   assign mul_rst = mul_rst_q | ~rst;

   // Pick the granted requester's operand pair out of the packed buses.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            a_sel = req_a[i*WIDTH +: WIDTH];
            b_sel = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Sequencer: accept, restart the multiplier, wait out its latency, hand back the result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         lat_id      <= '0;
         mul_rst_q   <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_product <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  mul_a     <= a_sel;
                  mul_b     <= b_sel;
                  lat_id    <= gnt_id;
                  ptr       <= next_ptr;
                  mul_rst_q <= 1'b1;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               mul_rst_q <= 1'b0;
               cnt       <= '0;
               state     <= RUN;
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(MUL_LAT - 1)) begin
                  rsp_product <= mul_product;
                  rsp_id      <= lat_id;
                  rsp_valid   <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: behavioural multiplier model,
// event logger, and scenario tasks comparing against a round-robin reference.
module tb_booth_mul_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [2*W-1:0]   rsp_product;
   logic             mul_rst;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic [2*W-1:0]   mul_product;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int mcnt     = 0;

   int             acc_id[$];
   logic [W-1:0]   acc_a[$];
   logic [W-1:0]   acc_b[$];
   logic [N-1:0]   acc_vld[$];
   int             acc_edge[$];
   int             rsp_rise[$];
   int             hs_id[$];
   logic [2*W-1:0] hs_prod[$];
   int             hs_edge[$];
   int             acc_cnt[N];
   int             seen_cnt[N];
   int             mulrst_cnt = 0;
   int             ready_cnt  = 0;
   bit             rsp_prev   = 1'b0;
   logic [N-1:0]   persist;

   booth_mul_arbiter #(
      .N_REQ   (N),
      .WIDTH   (W),
      .MUL_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .mul_rst     (mul_rst),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Signed product from plain integer arithmetic.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[2*W-1:0];
   endfunction

   // First valid requester at or above p, wrapping.
   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // External multiplier: garbage until LAT cycles after restart release.
   always @(posedge clk) begin
      if (mul_rst) mcnt <= 0;
      else if (mcnt < 1000) mcnt <= mcnt + 1;
   end
   assign mul_product = (mcnt >= LAT - 1) ? ref_mul(mul_a, mul_b) : (16'hDEAD ^ {mul_a, mul_b});

   always @(posedge clk) cyc <= cyc + 1;

   // Event logger: accepts, response rises and response handshakes.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
               acc_id.push_back(i);
               acc_a.push_back(req_a[i*W +: W]);
               acc_b.push_back(req_b[i*W +: W]);
               acc_vld.push_back(req_valid);
               acc_edge.push_back(cyc + 1);
               acc_cnt[i] = acc_cnt[i] + 1;
            end
         end
         if (rsp_valid === 1'b1 && !rsp_prev) rsp_rise.push_back(cyc);
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            hs_id.push_back(int'(rsp_id));
            hs_prod.push_back(rsp_product);
            hs_edge.push_back(cyc + 1);
         end
         if (mul_rst === 1'b1) mulrst_cnt = mulrst_cnt + 1;
         if (|req_ready) ready_cnt = ready_cnt + 1;
      end
      rsp_prev = (rsp_valid === 1'b1);
   end

   // Advance one cycle; requesters hold until granted, then drop unless persistent.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_cnt[i] != seen_cnt[i]) begin
            seen_cnt[i] = acc_cnt[i];
            if (!persist[i]) req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]      = 1'b1;
      req_a[i*W +: W]   = a;
      req_b[i*W +: W]   = b;
   endtask

   task automatic do_reset();
      req_valid = '0;
      persist   = '0;
      rst       = 1'b0;
      step();
      rst       = 1'b1;
   endtask

   task automatic wait_rsp(input int base, input int n, input int limit, output bit ok);
      for (int t = 0; t < limit && hs_id.size() < base + n; t++) step();
      ok = (hs_id.size() >= base + n);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom));
      step();
      step();
      @(negedge clk);
      n_checks++; if (mul_rst !== 1'b1) $display("[TB] FAIL reset_mul_rst: got %b want 1", mul_rst); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (mul_a !== 8'h00 || mul_b !== 8'h00) $display("[TB] FAIL reset_mul_ops: got %h/%h want 00/00", mul_a, mul_b); else n_pass++;
      n_checks++; if (rsp_id !== 2'd0 || rsp_product !== 16'h0000) $display("[TB] FAIL reset_rsp_data: got %0d/%h want 0/0000", rsp_id, rsp_product); else n_pass++;
      req_valid = '0;
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      n_checks++; if (mul_rst !== 1'b0) $display("[TB] FAIL idle_mul_rst: got %b want 0", mul_rst); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_basic();
      int ab, rb, hb, mr0, rc0;
      bit ok;
      ab = acc_id.size(); rb = rsp_rise.size(); hb = hs_id.size();
      mr0 = mulrst_cnt; rc0 = ready_cnt;
      rsp_ready = 1'b1;
      set_req(0, 8'd2, 8'd5);
      wait_rsp(hb, 1, 40, ok);
      n_checks++; if (!ok) $display("[TB] FAIL basic_timeout: got %0d responses want 1", hs_id.size() - hb); else n_pass++;
      n_checks++; if (acc_id[ab] !== 0) $display("[TB] FAIL basic_grant: got %0d want 0", acc_id[ab]); else n_pass++;
      n_checks++; if (hs_prod[hb] !== ref_mul(8'd2, 8'd5)) $display("[TB] FAIL basic_product: got %0d want %0d", hs_prod[hb], ref_mul(8'd2, 8'd5)); else n_pass++;
      n_checks++; if (hs_id[hb] !== 0) $display("[TB] FAIL basic_id: got %0d want 0", hs_id[hb]); else n_pass++;
      n_checks++; if (rsp_rise[rb] - acc_edge[ab] !== LAT + 1) $display("[TB] FAIL basic_latency: got %0d want %0d", rsp_rise[rb] - acc_edge[ab], LAT + 1); else n_pass++;
      n_checks++; if (mulrst_cnt - mr0 !== 1) $display("[TB] FAIL basic_mul_rst_len: got %0d want 1", mulrst_cnt - mr0); else n_pass++;
      n_checks++; if (ready_cnt - rc0 !== 1) $display("[TB] FAIL basic_ready_len: got %0d want 1", ready_cnt - rc0); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [W-1:0] ta[N];
      logic [W-1:0] tb[N];
      int ab, hb, ptr, exp;
      bit ok;
      ta = '{8'd5, 8'd2, 8'd7, 8'd3};
      tb = '{8'd5, 8'd6, 8'd5, 8'd3};
      do_reset();
      ab = acc_id.size(); hb = hs_id.size();
      for (int i = 0; i < N; i++) set_req(i, ta[i], tb[i]);
      wait_rsp(hb, 4, 120, ok);
      n_checks++; if (!ok) $display("[TB] FAIL rr_timeout: got %0d responses want 4", hs_id.size() - hb); else n_pass++;
      ptr = 0;
      for (int k = 0; k < 4 && ok; k++) begin
         exp = rr_pick(acc_vld[ab+k], ptr);
         ptr = (exp + 1) % N;
         n_checks++; if (acc_id[ab+k] !== exp) $display("[TB] FAIL rr_grant%0d: got %0d want %0d", k, acc_id[ab+k], exp); else n_pass++;
         n_checks++; if (hs_id[hb+k] !== exp) $display("[TB] FAIL rr_id%0d: got %0d want %0d", k, hs_id[hb+k], exp); else n_pass++;
         n_checks++; if (hs_prod[hb+k] !== ref_mul(ta[exp], tb[exp])) $display("[TB] FAIL rr_product%0d: got %0d want %0d", k, hs_prod[hb+k], ref_mul(ta[exp], tb[exp])); else n_pass++;
         if (k > 0) begin
            n_checks++; if (acc_edge[ab+k] - acc_edge[ab+k-1] !== LAT + 3) $display("[TB] FAIL rr_interval%0d: got %0d want %0d", k, acc_edge[ab+k] - acc_edge[ab+k-1], LAT + 3); else n_pass++;
         end
      end
   endtask

   task automatic test_signed();
      int hb;
      bit ok;
      hb = hs_id.size();
      set_req(2, 8'hFD, 8'd7);
      wait_rsp(hb, 1, 40, ok);
      n_checks++; if (!ok) $display("[TB] FAIL signed_timeout: got %0d responses want 1", hs_id.size() - hb); else n_pass++;
      n_checks++; if (hs_prod[hb] !== 16'hFFEB) $display("[TB] FAIL signed_product: got %h want ffeb", hs_prod[hb]); else n_pass++;
      n_checks++; if (hs_id[hb] !== 2) $display("[TB] FAIL signed_id: got %0d want 2", hs_id[hb]); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a1, b1, a3, b3;
      int hb, rb;
      bit ok;
      a1 = W'($urandom); b1 = W'($urandom);
      a3 = W'($urandom); b3 = W'($urandom);
      hb = hs_id.size(); rb = rsp_rise.size();
      rsp_ready = 1'b0;
      set_req(1, a1, b1);
      for (int t = 0; t < 40 && rsp_valid !== 1'b1; t++) step();
      n_checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL bp_valid_timeout: got %b want 1", rsp_valid); else n_pass++;
      set_req(3, a3, b3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL bp_hold%0d: got valid=%b busy=%b want 1/1", k, rsp_valid, busy); else n_pass++;
         n_checks++; if (rsp_product !== ref_mul(a1, b1) || rsp_id !== 2'd1) $display("[TB] FAIL bp_data%0d: got %h/%0d want %h/1", k, rsp_product, rsp_id, ref_mul(a1, b1)); else n_pass++;
         n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_ready%0d: got %b want 0000", k, req_ready); else n_pass++;
         step();
      end
      rsp_ready = 1'b1;
      step();
      n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("[TB] FAIL bp_release: got busy=%b valid=%b want 0/0", busy, rsp_valid); else n_pass++;
      wait_rsp(hb, 2, 60, ok);
      n_checks++; if (!ok) $display("[TB] FAIL bp_timeout: got %0d responses want 2", hs_id.size() - hb); else n_pass++;
      n_checks++; if (rsp_rise.size() - rb !== 2) $display("[TB] FAIL bp_rises: got %0d want 2", rsp_rise.size() - rb); else n_pass++;
      n_checks++; if (hs_id[hb] !== 1 || hs_prod[hb] !== ref_mul(a1, b1)) $display("[TB] FAIL bp_first: got %0d/%h want 1/%h", hs_id[hb], hs_prod[hb], ref_mul(a1, b1)); else n_pass++;
      n_checks++; if (hs_id[hb+1] !== 3 || hs_prod[hb+1] !== ref_mul(a3, b3)) $display("[TB] FAIL bp_second: got %0d/%h want 3/%h", hs_id[hb+1], hs_prod[hb+1], ref_mul(a3, b3)); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [W-1:0] a1, b1, a3, b3;
      int ab, hb, ptr, exp;
      int want[4];
      bit ok;
      want = '{1, 3, 1, 3};
      a1 = W'($urandom); b1 = W'($urandom);
      a3 = W'($urandom); b3 = W'($urandom);
      do_reset();
      ab = acc_id.size(); hb = hs_id.size();
      persist = 4'b1010;
      set_req(1, a1, b1);
      set_req(3, a3, b3);
      for (int t = 0; t < 120 && acc_id.size() < ab + 4; t++) step();
      req_valid = '0;
      persist   = '0;
      wait_rsp(hb, 4, 60, ok);
      n_checks++; if (!ok) $display("[TB] FAIL fair_timeout: got %0d responses want 4", hs_id.size() - hb); else n_pass++;
      ptr = 0;
      for (int k = 0; k < 4 && ok; k++) begin
         exp = rr_pick(acc_vld[ab+k], ptr);
         ptr = (exp + 1) % N;
         n_checks++; if (acc_id[ab+k] !== exp || exp !== want[k]) $display("[TB] FAIL fair_grant%0d: got %0d want %0d", k, acc_id[ab+k], want[k]); else n_pass++;
         n_checks++; if (hs_prod[hb+k] !== ((exp == 1) ? ref_mul(a1, b1) : ref_mul(a3, b3))) $display("[TB] FAIL fair_product%0d: got %h", k, hs_prod[hb+k]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] a1, b1, a2, b2;
      int ab, hb, rb, ptr, exp;
      bit ok;
      a1 = W'($urandom); b1 = W'($urandom);
      a2 = W'($urandom); b2 = W'($urandom);
      do_reset();
      rsp_ready = 1'b1;
      ab = acc_id.size(); hb = hs_id.size(); rb = rsp_rise.size();
      set_req(1, W'($urandom), W'($urandom));
      for (int t = 0; t < 20 && acc_id.size() == ab; t++) step();
      n_checks++; if (acc_id.size() !== ab + 1) $display("[TB] FAIL mid_accept: got %0d accepts want 1", acc_id.size() - ab); else n_pass++;
      for (int t = 0; t < 5; t++) step();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (mul_rst !== 1'b1 || req_ready !== 4'b0000) $display("[TB] FAIL mid_in_reset: got mul_rst=%b ready=%b want 1/0000", mul_rst, req_ready); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("[TB] FAIL mid_after_reset: got busy=%b valid=%b want 0/0", busy, rsp_valid); else n_pass++;
      rst = 1'b1;
      for (int t = 0; t < 15; t++) step();
      n_checks++; if (rsp_rise.size() !== rb || hs_id.size() !== hb) $display("[TB] FAIL mid_no_response: got %0d rises want 0", rsp_rise.size() - rb); else n_pass++;
      set_req(1, a1, b1);
      set_req(2, a2, b2);
      wait_rsp(hb, 2, 80, ok);
      n_checks++; if (!ok) $display("[TB] FAIL mid_timeout: got %0d responses want 2", hs_id.size() - hb); else n_pass++;
      ptr = 0;
      for (int k = 0; k < 2 && ok; k++) begin
         exp = rr_pick(acc_vld[ab+1+k], ptr);
         ptr = (exp + 1) % N;
         n_checks++; if (acc_id[ab+1+k] !== exp || hs_id[hb+k] !== exp) $display("[TB] FAIL mid_grant%0d: got %0d/%0d want %0d", k, acc_id[ab+1+k], hs_id[hb+k], exp); else n_pass++;
         n_checks++; if (hs_prod[hb+k] !== ((exp == 1) ? ref_mul(a1, b1) : ref_mul(a2, b2))) $display("[TB] FAIL mid_product%0d: got %h", k, hs_prod[hb+k]); else n_pass++;
      end
   endtask

   task automatic test_random();
      int ab, hb, rb, ptr, exp, nacc, nchk;
      do_reset();
      ab = acc_id.size(); hb = hs_id.size(); rb = rsp_rise.size();
      for (int t = 0; t < 3000 && acc_id.size() - ab < 24; t++) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] !== 1'b1 && $urandom_range(0, 3) == 0) set_req(i, W'($urandom), W'($urandom));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rsp_ready = 1'b1;
      for (int t = 0; t < 400 && (req_valid != '0 || hs_id.size() - hb < acc_id.size() - ab); t++) step();
      step();
      nacc = acc_id.size() - ab;
      n_checks++; if (nacc < 24) $display("[TB] FAIL rand_accepts: got %0d want >=24", nacc); else n_pass++;
      n_checks++; if (hs_id.size() - hb !== nacc) $display("[TB] FAIL rand_rsp_count: got %0d want %0d", hs_id.size() - hb, nacc); else n_pass++;
      nchk = (hs_id.size() - hb < nacc) ? hs_id.size() - hb : nacc;
      if (rsp_rise.size() - rb < nchk) nchk = rsp_rise.size() - rb;
      ptr = 0;
      for (int k = 0; k < nchk; k++) begin
         exp = rr_pick(acc_vld[ab+k], ptr);
         ptr = (exp + 1) % N;
         n_checks++; if (acc_id[ab+k] !== exp) $display("[TB] FAIL rand_grant%0d: got %0d want %0d", k, acc_id[ab+k], exp); else n_pass++;
         n_checks++; if (hs_id[hb+k] !== exp) $display("[TB] FAIL rand_id%0d: got %0d want %0d", k, hs_id[hb+k], exp); else n_pass++;
         n_checks++; if (hs_prod[hb+k] !== ref_mul(acc_a[ab+k], acc_b[ab+k])) $display("[TB] FAIL rand_product%0d: got %h want %h", k, hs_prod[hb+k], ref_mul(acc_a[ab+k], acc_b[ab+k])); else n_pass++;
         n_checks++; if (rsp_rise[rb+k] - acc_edge[ab+k] !== LAT + 1) $display("[TB] FAIL rand_latency%0d: got %0d want %0d", k, rsp_rise[rb+k] - acc_edge[ab+k], LAT + 1); else n_pass++;
         if (k > 0) begin
            n_checks++; if (acc_edge[ab+k] < hs_edge[hb+k-1] + 1) $display("[TB] FAIL rand_gap%0d: got accept edge %0d want >= %0d", k, acc_edge[ab+k], hs_edge[hb+k-1] + 1); else n_pass++;
         end
      end
   endtask

   // Global bound in case a wait loop is ever mis-sized.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      persist   = '0;
      for (int i = 0; i < N; i++) seen_cnt[i] = 0;
      test_reset();
      test_basic();
      test_round_robin();
      test_signed();
      test_backpressure();
      test_fairness();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
